// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game score controller.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [6:0]  BLANK_SEG = 7'h7F;
  localparam logic [11:0] SCORE_MAX = 12'h999;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the score counter; carry fires when an increment rolls 9 over.
module bcd_digit
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == 4'd9);

endmodule

// File: rtl/seg7.sv
// BCD to active-low 7-segment decoder, leds[0] = segment a ... leds[6] = segment g.
module seg7
  import flappy_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] leds
);

  always_comb begin
    leds = BLANK_SEG;
    case (bcd)
      4'd0: leds = 7'h40;
      4'd1: leds = 7'h79;
      4'd2: leds = 7'h24;
      4'd3: leds = 7'h30;
      4'd4: leds = 7'h19;
      4'd5: leds = 7'h12;
      4'd6: leds = 7'h02;
      4'd7: leds = 7'h78;
      4'd8: leds = 7'h00;
      4'd9: leds = 7'h10;
      default: leds = BLANK_SEG;
    endcase
  end

endmodule

// File: rtl/score_ctrl.sv
// Game state sequencer, saturating BCD score, high-score latch and flashing display.
//   state | meaning
//   IDLE  | after reset, score held at 000, waiting for start
//   PLAY  | game running, pass edges add a point, crash ends the game
//   OVER  | score frozen, display flashes, start begins a new game
module score_ctrl
  import flappy_pkg::*;
#(
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pass,
  input  logic        crash,
  input  logic        show_hi,
  output logic [1:0]  state,
  output logic [11:0] score,
  output logic [11:0] hiscore,
  output logic        new_hi,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2
);

  localparam int CW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_DIV - 1);
  localparam logic [CW-1:0] FLASH_HALF = CW'(FLASH_DIV / 2);

  game_state_t   state_q, state_d;
  logic          start_q, pass_q;
  logic [11:0]   hiscore_q, hiscore_d;
  logic          new_hi_q, new_hi_d;
  logic [CW-1:0] flash_q, flash_d;

  logic          start_edge, pass_edge;
  logic          clr, inc_ones;
  logic          carry0, carry1, carry_unused;
  logic [3:0]    dig0, dig1, dig2;
  logic [11:0]   disp;
  logic          blank;
  logic [6:0]    seg0, seg1, seg2;

  assign start_edge = start & ~start_q;
  assign pass_edge  = pass & ~pass_q;

  always_comb begin
    state_d   = state_q;
    hiscore_d = hiscore_q;
    new_hi_d  = new_hi_q;
    clr       = 1'b0;
    inc_ones  = 1'b0;
    case (state_q)
      IDLE: begin
        clr      = 1'b1;
        new_hi_d = 1'b0;
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        // Crash takes precedence over a coincident pass edge.
        if (crash) begin
          state_d = OVER;
          if (score > hiscore_q) begin
            hiscore_d = score;
            new_hi_d  = 1'b1;
          end
        end else if (pass_edge && (score != SCORE_MAX)) begin
          inc_ones = 1'b1;
        end
      end
      OVER: begin
        if (start_edge) begin
          state_d  = PLAY;
          clr      = 1'b1;
          new_hi_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        clr      = 1'b1;
        new_hi_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    flash_d = '0;
    if ((state_q == OVER) && (state_d == OVER)) begin
      flash_d = (flash_q == FLASH_LAST) ? '0 : flash_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      pass_q    <= 1'b0;
      hiscore_q <= 12'h000;
      new_hi_q  <= 1'b0;
      flash_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      pass_q    <= pass;
      hiscore_q <= hiscore_d;
      new_hi_q  <= new_hi_d;
      flash_q   <= flash_d;
    end
  end

  bcd_digit u_ones (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc_ones), .digit(dig0), .carry(carry0)
  );
  bcd_digit u_tens (
    .clk(clk), .reset(reset), .clr(clr), .inc(carry0), .digit(dig1), .carry(carry1)
  );
  bcd_digit u_hund (
    .clk(clk), .reset(reset), .clr(clr), .inc(carry1), .digit(dig2), .carry(carry_unused)
  );

  assign score = {dig2, dig1, dig0};

  assign disp  = (show_hi && (state_q != PLAY)) ? hiscore_q : score;
  assign blank = (state_q == OVER) && (flash_q >= FLASH_HALF);

  seg7 u_seg0 (.bcd(disp[3:0]),  .leds(seg0));
  seg7 u_seg1 (.bcd(disp[7:4]),  .leds(seg1));
  seg7 u_seg2 (.bcd(disp[11:8]), .leds(seg2));

  assign HEX0    = blank ? BLANK_SEG : seg0;
  assign HEX1    = blank ? BLANK_SEG : seg1;
  assign HEX2    = blank ? BLANK_SEG : seg2;
  assign state   = state_q;
  assign hiscore = hiscore_q;
  assign new_hi  = new_hi_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: stimulus queues expectations, a monitor checks them after each edge.
module tb_score_ctrl;

  localparam int K_STATE = 0;
  localparam int K_SCORE = 1;
  localparam int K_HI    = 2;
  localparam int K_NEWHI = 3;
  localparam int K_HEX   = 4;
  localparam logic [20:0] HEX_BLANK = 21'h1FFFFF;

  typedef struct {
    int          cyc;
    int          kind;
    logic [20:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, pass, crash, show_hi;
  logic [1:0]  state;
  logic [11:0] score, hiscore;
  logic        new_hi;
  logic [6:0]  hex0, hex1, hex2;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  int exp_state, exp_score, exp_hi, exp_newhi;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_ctrl #(.FLASH_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pass(pass), .crash(crash),
    .show_hi(show_hi), .state(state), .score(score), .hiscore(hiscore),
    .new_hi(new_hi), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] tobcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [20:0] hex3(input int v);
    return {seg_tab[(v / 100) % 10], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  // Expectation applies to the outputs right after the next rising edge.
  function automatic void expect_(input int kind, input logic [20:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endfunction

  function automatic void expect_all(input string name);
    expect_(K_STATE, 21'(exp_state), name);
    expect_(K_SCORE, 21'(tobcd(exp_score)), name);
    expect_(K_HI, 21'(tobcd(exp_hi)), name);
    expect_(K_NEWHI, 21'(exp_newhi), name);
  endfunction

  always @(posedge clk) begin
    exp_t        e;
    logic [20:0] act;
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_STATE: act = {19'd0, state};
        K_SCORE: act = {9'd0, score};
        K_HI:    act = {9'd0, hiscore};
        K_NEWHI: act = {20'd0, new_hi};
        default: act = {hex2, hex1, hex0};
      endcase
      n_total++;
      if (e.cyc == cyc && act === e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s (kind %0d, cycle %0d): got %0h, expected %0h", e.name, e.kind, cyc, act, e.val);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_state = 0; exp_score = 0; exp_hi = 0; exp_newhi = 0;
    expect_all("reset");
    expect_(K_HEX, hex3(0), "reset_hex");
    tick();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    if (exp_state != 1) begin
      exp_state = 1; exp_score = 0; exp_newhi = 0;
    end
    expect_(K_STATE, 21'(exp_state), "start_state");
    expect_(K_SCORE, 21'(tobcd(exp_score)), "start_score");
    expect_(K_NEWHI, 21'(exp_newhi), "start_new_hi");
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic pass_pulse(input bit chk);
    pass = 1'b1;
    if (exp_state == 1 && exp_score < 999) exp_score++;
    if (chk) expect_(K_SCORE, 21'(tobcd(exp_score)), "pass_score");
    tick();
    pass = 1'b0;
    tick();
  endtask

  task automatic crash_now();
    crash = 1'b1;
    exp_state = 2;
    if (exp_score > exp_hi) begin
      exp_hi = exp_score;
      exp_newhi = 1;
    end
    expect_all("crash");
    expect_(K_HEX, hex3(exp_score), "over_first_hex");
    tick();
    crash = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; pass = 1'b0; crash = 1'b0; show_hi = 1'b0;
    repeat (2) tick();
    do_reset();

    // IDLE ignores pass and crash
    pass_pulse(1);
    crash = 1'b1;
    expect_(K_STATE, 21'd0, "idle_ignores_crash");
    tick();
    crash = 1'b0;

    // record 5, then record 7, then 3 does not beat 7
    start_pulse();
    repeat (5) pass_pulse(1);
    crash_now();
    start_pulse();
    repeat (7) pass_pulse(1);
    crash_now();
    start_pulse();
    repeat (3) pass_pulse(1);
    crash_now();

    // flash with FLASH_DIV=4: two cycles digits, two cycles blank
    expect_(K_HEX, hex3(3), "flash_cnt1");
    tick();
    expect_(K_HEX, HEX_BLANK, "flash_cnt2");
    tick();
    expect_(K_HEX, HEX_BLANK, "flash_cnt3");
    tick();
    show_hi = 1'b1;
    expect_(K_HEX, hex3(7), "flash_hi_cnt0");
    tick();
    expect_(K_HEX, hex3(7), "flash_hi_cnt1");
    tick();
    expect_(K_HEX, HEX_BLANK, "flash_hi_cnt2");
    tick();

    // OVER ignores pass and crash
    pass_pulse(1);
    crash = 1'b1;
    expect_all("over_ignores_crash");
    tick();
    crash = 1'b0;

    // restart with show_hi still high: PLAY shows the score
    expect_(K_HEX, hex3(0), "play_ignores_show_hi");
    start_pulse();
    show_hi = 1'b0;
    repeat (4) pass_pulse(1);

    // coincident pass edge and crash
    pass = 1'b1; crash = 1'b1;
    exp_state = 2;
    expect_all("pass_and_crash");
    tick();
    pass = 1'b0; crash = 1'b0;
    repeat (3) tick();

    // reset mid-OVER clears everything including hiscore
    show_hi = 1'b1;
    do_reset();
    show_hi = 1'b0;

    start_pulse();
    repeat (12) pass_pulse(1);
    expect_(K_STATE, 21'd1, "twelve_state");
    expect_(K_HEX, hex3(12), "twelve_hex");
    tick();

    // pass held high five cycles counts once
    pass = 1'b1;
    exp_score = 13;
    repeat (5) begin
      expect_(K_SCORE, 21'(tobcd(13)), "pass_held");
      tick();
    end
    pass = 1'b0;
    tick();

    start_pulse();

    while (exp_score < 99) pass_pulse(0);
    expect_(K_SCORE, 21'(tobcd(99)), "score_099");
    tick();
    pass_pulse(1);
    while (exp_score < 999) pass_pulse(0);
    expect_(K_SCORE, 21'(tobcd(999)), "score_999");
    tick();
    pass_pulse(1);
    pass_pulse(1);
    expect_(K_HEX, hex3(999), "hex_999");
    tick();
    crash_now();
    tick();

    repeat (5) tick();
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, expected 0", sb.size());
      n_total += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
